decode_execute_stage: RTL and testbench

- Decode stage of the Y86-64 pipeline.
- Takes the fetched instruction from the D pipeline register and derives the register-file read addresses srcA/srcB and the write-back destinations dstE/dstM.
- Merges register-file read data with forwarded values from the E/M/W stages, then latches the result into the E pipeline register feeding execute.
- Sits directly downstream of the register file read ports, which are driven combinationally by this block's srcA/srcB.

---
 rtl/decode_execute_stage_pkg.sv | 59 +++++
 rtl/decode_execute_stage_if.sv | 63 ++++++
 rtl/decode_execute_stage_fwd_select.sv | 42 ++++
 rtl/decode_execute_stage.sv | 115 +++++++++++
 tb/tb_decode_execute_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/decode_execute_stage_pkg.sv
// Shared Y86-64 constants and the E pipeline register layout for the decode stage.
package decode_execute_stage_pkg;

    localparam int DATA_WID = 64;
    localparam int ADDR_WID = 4;
    localparam int STAT_WID = 3;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register indices
    localparam logic [ADDR_WID-1:0] RSP   = 4'h4;
    localparam logic [ADDR_WID-1:0] RNONE = 4'hF;

    // Status codes
    localparam logic [STAT_WID-1:0] S_BUB = 3'd0;
    localparam logic [STAT_WID-1:0] S_AOK = 3'd1;
    localparam logic [STAT_WID-1:0] S_HLT = 3'd2;
    localparam logic [STAT_WID-1:0] S_ADR = 3'd3;
    localparam logic [STAT_WID-1:0] S_INS = 3'd4;

    typedef struct packed {
        logic [STAT_WID-1:0] stat;
        logic [3:0]          icode;
        logic [3:0]          ifun;
        logic [DATA_WID-1:0] valC;
        logic [DATA_WID-1:0] valA;
        logic [DATA_WID-1:0] valB;
        logic [ADDR_WID-1:0] dstE;
        logic [ADDR_WID-1:0] dstM;
        logic [ADDR_WID-1:0] srcA;
        logic [ADDR_WID-1:0] srcB;
    } e_reg_t;

    // Contents of the E register when it holds a bubble
    function automatic e_reg_t e_bubble_val();
        e_reg_t r;
        r       = '0;
        r.stat  = S_BUB;
        r.icode = INOP;
        r.dstE  = RNONE;
        r.dstM  = RNONE;
        r.srcA  = RNONE;
        r.srcB  = RNONE;
        return r;
    endfunction

endpackage

// File: rtl/decode_execute_stage_if.sv
// Signal bundle between the decode stage and its surrounding pipeline.
interface decode_execute_stage_if;
    import decode_execute_stage_pkg::*;

    logic [STAT_WID-1:0] D_stat;
    logic [3:0]          D_icode;
    logic [3:0]          D_ifun;
    logic [ADDR_WID-1:0] D_rA;
    logic [ADDR_WID-1:0] D_rB;
    logic [DATA_WID-1:0] D_valC;
    logic [DATA_WID-1:0] D_valP;
    logic [ADDR_WID-1:0] srcA;
    logic [ADDR_WID-1:0] srcB;
    logic [DATA_WID-1:0] rf_valA;
    logic [DATA_WID-1:0] rf_valB;
    logic [ADDR_WID-1:0] e_dstE;
    logic [DATA_WID-1:0] e_valE;
    logic [ADDR_WID-1:0] M_dstE;
    logic [DATA_WID-1:0] M_valE;
    logic [ADDR_WID-1:0] M_dstM;
    logic [DATA_WID-1:0] m_valM;
    logic [ADDR_WID-1:0] W_dstE;
    logic [DATA_WID-1:0] W_valE;
    logic [ADDR_WID-1:0] W_dstM;
    logic [DATA_WID-1:0] W_valM;
    logic                E_stall;
    logic                E_bubble;
    logic [STAT_WID-1:0] E_stat;
    logic [3:0]          E_icode;
    logic [3:0]          E_ifun;
    logic [DATA_WID-1:0] E_valC;
    logic [DATA_WID-1:0] E_valA;
    logic [DATA_WID-1:0] E_valB;
    logic [ADDR_WID-1:0] E_dstE;
    logic [ADDR_WID-1:0] E_dstM;
    logic [ADDR_WID-1:0] E_srcA;
    logic [ADDR_WID-1:0] E_srcB;

    // Decode stage side
    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  rf_valA, rf_valB,
        input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        input  W_dstE, W_valE, W_dstM, W_valM,
        input  E_stall, E_bubble,
        output srcA, srcB,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );

    // Pipeline / register file side
    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output rf_valA, rf_valB,
        output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        output W_dstE, W_valE, W_dstM, W_valM,
        output E_stall, E_bubble,
        input  srcA, srcB,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );

endinterface

// File: rtl/decode_execute_stage_fwd_select.sv
// Single-operand forwarding mux: valP override (optional), then youngest stage first.
module decode_execute_stage_fwd_select
    import decode_execute_stage_pkg::*;
#(
    parameter bit USE_VALP = 1'b0
) (
    input  logic [3:0]          icode_i,
    input  logic [ADDR_WID-1:0] src_i,
    input  logic [DATA_WID-1:0] valP_i,
    input  logic [DATA_WID-1:0] rf_val_i,
    input  logic [ADDR_WID-1:0] e_dstE_i,
    input  logic [DATA_WID-1:0] e_valE_i,
    input  logic [ADDR_WID-1:0] M_dstM_i,
    input  logic [DATA_WID-1:0] m_valM_i,
    input  logic [ADDR_WID-1:0] M_dstE_i,
    input  logic [DATA_WID-1:0] M_valE_i,
    input  logic [ADDR_WID-1:0] W_dstM_i,
    input  logic [DATA_WID-1:0] W_valM_i,
    input  logic [ADDR_WID-1:0] W_dstE_i,
    input  logic [DATA_WID-1:0] W_valE_i,
    output logic [DATA_WID-1:0] val_o
);

    logic src_vld;
    logic use_valp;

    // RNONE is a "no register" marker and must never hit a forwarding source
    assign src_vld  = (src_i != RNONE);
    assign use_valp = USE_VALP && ((icode_i == ICALL) || (icode_i == IJXX));

    // Strict priority: valP, execute, memory (M before E), write-back (M before E), register file
    always_comb begin
        val_o = rf_val_i;
        if (use_valp)                            val_o = valP_i;
        else if (src_vld && src_i == e_dstE_i)   val_o = e_valE_i;
        else if (src_vld && src_i == M_dstM_i)   val_o = m_valM_i;
        else if (src_vld && src_i == M_dstE_i)   val_o = M_valE_i;
        else if (src_vld && src_i == W_dstM_i)   val_o = W_valM_i;
        else if (src_vld && src_i == W_dstE_i)   val_o = W_valE_i;
    end

endmodule

// File: rtl/decode_execute_stage.sv
// Y86-64 decode stage: register index decode, operand forwarding, E pipeline register.
module decode_execute_stage
    import decode_execute_stage_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    decode_execute_stage_if.slave bus
);

    logic [ADDR_WID-1:0] src_a;
    logic [ADDR_WID-1:0] src_b;
    logic [ADDR_WID-1:0] dst_e;
    logic [ADDR_WID-1:0] dst_m;
    logic [DATA_WID-1:0] d_val_a;
    logic [DATA_WID-1:0] d_val_b;
    e_reg_t              e_q;
    e_reg_t              e_d;

    // Register index decode; unknown icodes leave every index at RNONE
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.D_icode)
            IRRMOVQ: begin src_a = bus.D_rA; dst_e = bus.D_rB; end
            IIRMOVQ: begin dst_e = bus.D_rB; end
            IRMMOVQ: begin src_a = bus.D_rA; src_b = bus.D_rB; end
            IMRMOVQ: begin src_b = bus.D_rB; dst_m = bus.D_rA; end
            IOPQ:    begin src_a = bus.D_rA; src_b = bus.D_rB; dst_e = bus.D_rB; end
            ICALL:   begin src_b = RSP; dst_e = RSP; end
            IRET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            IPUSHQ:  begin src_a = bus.D_rA; src_b = RSP; dst_e = RSP; end
            IPOPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = bus.D_rA; end
            default: ;
        endcase
    end

    // Register file read addresses are live every cycle, independent of stall
    assign bus.srcA = src_a;
    assign bus.srcB = src_b;

    decode_execute_stage_fwd_select #(.USE_VALP(1'b1)) u_fwd_a (
        .icode_i  (bus.D_icode),
        .src_i    (src_a),
        .valP_i   (bus.D_valP),
        .rf_val_i (bus.rf_valA),
        .e_dstE_i (bus.e_dstE),
        .e_valE_i (bus.e_valE),
        .M_dstM_i (bus.M_dstM),
        .m_valM_i (bus.m_valM),
        .M_dstE_i (bus.M_dstE),
        .M_valE_i (bus.M_valE),
        .W_dstM_i (bus.W_dstM),
        .W_valM_i (bus.W_valM),
        .W_dstE_i (bus.W_dstE),
        .W_valE_i (bus.W_valE),
        .val_o    (d_val_a)
    );

    decode_execute_stage_fwd_select #(.USE_VALP(1'b0)) u_fwd_b (
        .icode_i  (bus.D_icode),
        .src_i    (src_b),
        .valP_i   (bus.D_valP),
        .rf_val_i (bus.rf_valB),
        .e_dstE_i (bus.e_dstE),
        .e_valE_i (bus.e_valE),
        .M_dstM_i (bus.M_dstM),
        .m_valM_i (bus.m_valM),
        .M_dstE_i (bus.M_dstE),
        .M_valE_i (bus.M_valE),
        .W_dstM_i (bus.W_dstM),
        .W_valM_i (bus.W_valM),
        .W_dstE_i (bus.W_dstE),
        .W_valE_i (bus.W_valE),
        .val_o    (d_val_b)
    );

    // Next E contents: bubble beats stall, stall beats load
    always_comb begin
        e_d = e_q;
        if (bus.E_bubble) begin
            e_d = e_bubble_val();
        end else if (!bus.E_stall) begin
            e_d.stat  = bus.D_stat;
            e_d.icode = bus.D_icode;
            e_d.ifun  = bus.D_ifun;
            e_d.valC  = bus.D_valC;
            e_d.valA  = d_val_a;
            e_d.valB  = d_val_b;
            e_d.dstE  = dst_e;
            e_d.dstM  = dst_m;
            e_d.srcA  = src_a;
            e_d.srcB  = src_b;
        end
    end

    // E pipeline register; reset discards whatever was in flight
    always_ff @(posedge CLK) begin
        if (RST) e_q <= e_bubble_val();
        else     e_q <= e_d;
    end

    assign bus.E_stat  = e_q.stat;
    assign bus.E_icode = e_q.icode;
    assign bus.E_ifun  = e_q.ifun;
    assign bus.E_valC  = e_q.valC;
    assign bus.E_valA  = e_q.valA;
    assign bus.E_valB  = e_q.valB;
    assign bus.E_dstE  = e_q.dstE;
    assign bus.E_dstM  = e_q.dstM;
    assign bus.E_srcA  = e_q.srcA;
    assign bus.E_srcB  = e_q.srcB;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed bench for decode_execute_stage: decode, forwarding priority, stall/bubble/reset.
module tb_decode_execute_stage;
    import decode_execute_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    decode_execute_stage_if bus ();

    decode_execute_stage dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_fwd();
        bus.e_dstE = 4'hF; bus.e_valE = 64'hE0E0;
        bus.M_dstE = 4'hF; bus.M_valE = 64'hE1E1;
        bus.M_dstM = 4'hF; bus.m_valM = 64'hE2E2;
        bus.W_dstE = 4'hF; bus.W_valE = 64'hE3E3;
        bus.W_dstM = 4'hF; bus.W_valM = 64'hE4E4;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        bus.D_icode = ic; bus.D_ifun = 4'h0;
        bus.D_rA = ra; bus.D_rB = rb;
        bus.D_valC = vc; bus.D_valP = vp;
    endtask

    initial begin
        bus.D_stat = 3'd1;
        set_d(4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        bus.rf_valA = 64'h0; bus.rf_valB = 64'h0;
        bus.E_stall = 1'b0; bus.E_bubble = 1'b0;
        clr_fwd();

        // Reset loads a bubble
        tick();
        chk("rst_icode", bus.E_icode, 64'h1);
        chk("rst_stat",  bus.E_stat,  64'h0);
        chk("rst_dstE",  bus.E_dstE,  64'hF);
        chk("rst_dstM",  bus.E_dstM,  64'hF);
        chk("rst_srcA",  bus.E_srcA,  64'hF);
        chk("rst_srcB",  bus.E_srcB,  64'hF);
        chk("rst_valA",  bus.E_valA,  64'h0);
        rst = 1'b0;

        // OPQ, no forwarding
        set_d(4'h6, 4'h2, 4'h3, 64'h0, 64'h2);
        bus.rf_valA = 64'h5; bus.rf_valB = 64'h7;
        #1;
        chk("opq_srcA", bus.srcA, 64'h2);
        chk("opq_srcB", bus.srcB, 64'h3);
        tick();
        chk("opq_valA",  bus.E_valA,  64'h5);
        chk("opq_valB",  bus.E_valB,  64'h7);
        chk("opq_dstE",  bus.E_dstE,  64'h3);
        chk("opq_dstM",  bus.E_dstM,  64'hF);
        chk("opq_icode", bus.E_icode, 64'h6);
        chk("opq_stat",  bus.E_stat,  64'h1);

        // Forwarding priority: e beats M, W_dstE feeds B
        bus.e_dstE = 4'h2; bus.e_valE = 64'h11;
        bus.M_dstM = 4'h2; bus.m_valM = 64'h22;
        bus.W_dstE = 4'h3; bus.W_valE = 64'h33;
        tick();
        chk("fwd_e_valA", bus.E_valA, 64'h11);
        chk("fwd_W_valB", bus.E_valB, 64'h33);

        // Without the execute match, M_dstM wins over W and rf
        bus.e_dstE = 4'hF;
        bus.W_dstM = 4'h2; bus.W_valM = 64'h44;
        tick();
        chk("fwd_m_valA", bus.E_valA, 64'h22);
        // W_dstM beats W_dstE for the same register
        bus.M_dstM = 4'hF;
        bus.W_dstE = 4'h2;
        tick();
        chk("fwd_Wm_valA", bus.E_valA, 64'h44);

        // CALL: valP overrides; srcB=RSP forwarded from M_dstE
        clr_fwd();
        set_d(4'h8, 4'hF, 4'hF, 64'h1000, 64'h40);
        bus.e_dstE = 4'hF;
        bus.M_dstE = 4'h4; bus.M_valE = 64'h55;
        #1;
        chk("call_srcB", bus.srcB, 64'h4);
        tick();
        chk("call_valA", bus.E_valA, 64'h40);
        chk("call_valB", bus.E_valB, 64'h55);
        chk("call_dstE", bus.E_dstE, 64'h4);
        chk("call_srcA", bus.E_srcA, 64'hF);

        // PUSHQ with rA=RNONE: RNONE never matches a forward source
        clr_fwd();
        set_d(4'hA, 4'hF, 4'hF, 64'h0, 64'h8);
        bus.W_dstE = 4'hF; bus.W_valE = 64'h99;
        bus.rf_valA = 64'h77; bus.rf_valB = 64'h88;
        tick();
        chk("push_valA", bus.E_valA, 64'h77);
        chk("push_valB", bus.E_valB, 64'h88);
        chk("push_srcB", bus.E_srcB, 64'h4);

        // POPQ: srcA=RSP, dstM=rA
        set_d(4'hB, 4'h7, 4'hF, 64'h0, 64'h2);
        tick();
        chk("pop_srcA", bus.E_srcA, 64'h4);
        chk("pop_dstM", bus.E_dstM, 64'h7);
        chk("pop_dstE", bus.E_dstE, 64'h4);

        // Stall holds E while decode keeps following D
        set_d(4'h6, 4'h1, 4'h2, 64'h0, 64'h2);
        bus.rf_valA = 64'hA; bus.rf_valB = 64'hB;
        tick();
        bus.E_stall = 1'b1;
        set_d(4'h3, 4'hF, 4'h9, 64'hDEAD, 64'hA);
        bus.rf_valA = 64'h123;
        tick();
        chk("stall_srcA_live", bus.srcA, 64'hF);
        set_d(4'h2, 4'h5, 4'h6, 64'hBEEF, 64'h2);
        tick();
        chk("stall_icode", bus.E_icode, 64'h6);
        chk("stall_valA",  bus.E_valA,  64'hA);
        chk("stall_valB",  bus.E_valB,  64'hB);
        chk("stall_dstE",  bus.E_dstE,  64'h2);

        // Bubble wins over stall
        bus.E_bubble = 1'b1;
        tick();
        chk("bub_icode", bus.E_icode, 64'h1);
        chk("bub_stat",  bus.E_stat,  64'h0);
        chk("bub_valA",  bus.E_valA,  64'h0);
        chk("bub_dstE",  bus.E_dstE,  64'hF);

        // Release: MRMOVQ loads
        bus.E_stall = 1'b0; bus.E_bubble = 1'b0;
        set_d(4'h5, 4'h5, 4'h6, 64'h100, 64'hA);
        tick();
        chk("mr_icode", bus.E_icode, 64'h5);
        chk("mr_dstM",  bus.E_dstM,  64'h5);
        chk("mr_dstE",  bus.E_dstE,  64'hF);
        chk("mr_srcB",  bus.E_srcB,  64'h6);
        chk("mr_valC",  bus.E_valC,  64'h100);

        // Unknown icode: indices RNONE, fields and stat pass through
        bus.D_stat = 3'd4;
        set_d(4'hC, 4'h1, 4'h2, 64'h77, 64'h2);
        bus.D_ifun = 4'h3;
        tick();
        chk("unk_icode", bus.E_icode, 64'hC);
        chk("unk_ifun",  bus.E_ifun,  64'h3);
        chk("unk_stat",  bus.E_stat,  64'h4);
        chk("unk_srcA",  bus.E_srcA,  64'hF);
        chk("unk_dstE",  bus.E_dstE,  64'hF);

        // Mid-stream reset discards the instruction
        bus.D_stat = 3'd1;
        set_d(4'h6, 4'h1, 4'h2, 64'h0, 64'h2);
        rst = 1'b1;
        tick();
        chk("rst2_icode", bus.E_icode, 64'h1);
        chk("rst2_valA",  bus.E_valA,  64'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_icode", bus.E_icode, 64'h6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
